// File: rtl/odo_pkg.sv
// Shared types and default constants for the distance odometer.
package odo_pkg;

  localparam int CIRC_W_DEFAULT  = 8;
  localparam int UNIT_CM_DEFAULT = 10000;
  localparam int TRIP_W_DEFAULT  = 14;
  localparam int TOTAL_W_DEFAULT = 20;
  localparam int LOCKOUT_DEFAULT = 255;

  // Debounce FSM states.
  typedef enum logic [1:0] {
    ST_WAIT_HIGH = 2'd0,
    ST_LOCKOUT   = 2'd1,
    ST_WAIT_LOW  = 2'd2
  } deb_state_e;

endpackage

// File: rtl/reed_debounce.sv
// Reed-switch synchroniser and lockout debouncer: one rev pulse per
// accepted rising level, bounce inside the lockout window is ignored and
// a level held high never produces a second rev.
module reed_debounce
  import odo_pkg::*;
#(
  parameter int LOCKOUT = LOCKOUT_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic reed,
  output logic rev
);

  localparam int LOCK_W = (LOCKOUT > 1) ? $clog2(LOCKOUT) : 1;
  localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCKOUT - 1);

  logic              sync1;
  logic              rs;
  deb_state_e        state;
  deb_state_e        state_nxt;
  logic [LOCK_W-1:0] cnt;
  logic [LOCK_W-1:0] cnt_nxt;

  // Two-flop synchroniser for the raw asynchronous reed level.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      rs    <= 1'b0;
    end else begin
      sync1 <= reed;
      rs    <= sync1;
    end
  end

  // FSM state and lockout counter registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_WAIT_HIGH;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic; rev is a Mealy output of WAIT_HIGH seeing rs high.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rev       = 1'b0;
    case (state)
      ST_WAIT_HIGH: begin
        if (rs) begin
          rev       = 1'b1;
          cnt_nxt   = LOCK_LOAD;
          state_nxt = ST_LOCKOUT;
        end
      end
      ST_LOCKOUT: begin
        if (cnt == '0) begin
          state_nxt = ST_WAIT_LOW;
        end else begin
          cnt_nxt = cnt - LOCK_W'(1);
        end
      end
      ST_WAIT_LOW: begin
        if (!rs) begin
          state_nxt = ST_WAIT_HIGH;
        end
      end
      default: begin
        state_nxt = ST_WAIT_HIGH;
      end
    endcase
  end

endmodule

// File: rtl/distance_odometer.sv
// Bicycle-style odometer: accumulates wheel circumference per revolution,
// emits a unit tick each time a full distance unit is completed and keeps
// trip and lifetime counters with saturate-or-wrap behaviour.
module distance_odometer
  import odo_pkg::*;
#(
  parameter int CIRC_W  = CIRC_W_DEFAULT,
  parameter int UNIT    = UNIT_CM_DEFAULT,
  parameter int TRIP_W  = TRIP_W_DEFAULT,
  parameter int TOTAL_W = TOTAL_W_DEFAULT,
  parameter int LOCKOUT = LOCKOUT_DEFAULT,
  parameter int WRAP    = 0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               reed,
  input  logic [CIRC_W-1:0]  circ,
  input  logic               trip_clr,
  output logic [TRIP_W-1:0]  trip_dist,
  output logic [TOTAL_W-1:0] total_dist,
  output logic               unit_tick,
  output logic               overflow
);

  // acc < UNIT and circ < 2^CIRC_W, so acc+circ always fits in ACC_W bits.
  localparam int ACC_W = $clog2(UNIT + (1 << CIRC_W));
  localparam logic [ACC_W-1:0] UNIT_V = ACC_W'(UNIT);

  logic               rev;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_nxt;
  logic [ACC_W-1:0]   sum;
  logic               unit_evt;
  logic [TRIP_W-1:0]  trip_nxt;
  logic [TOTAL_W-1:0] total_nxt;
  logic               ovf_nxt;

  reed_debounce #(
    .LOCKOUT (LOCKOUT)
  ) u_deb (
    .clock (clock),
    .reset (reset),
    .reed  (reed),
    .rev   (rev)
  );

  assign sum       = acc + ACC_W'(circ);
  assign unit_evt  = rev && (sum >= UNIT_V);
  assign unit_tick = unit_evt;

  // Accumulator and counter next values; trip clear overrides a unit event.
  always_comb begin
    acc_nxt   = acc;
    trip_nxt  = trip_dist;
    total_nxt = total_dist;
    ovf_nxt   = overflow;
    if (rev) begin
      acc_nxt = unit_evt ? (sum - UNIT_V) : sum;
    end
    if (unit_evt) begin
      if (&total_dist) begin
        total_nxt = (WRAP != 0) ? '0 : total_dist;
        ovf_nxt   = 1'b1;
      end else begin
        total_nxt = total_dist + TOTAL_W'(1);
      end
      if (!trip_clr) begin
        if (&trip_dist) begin
          trip_nxt = (WRAP != 0) ? '0 : trip_dist;
          ovf_nxt  = 1'b1;
        end else begin
          trip_nxt = trip_dist + TRIP_W'(1);
        end
      end
    end
    if (trip_clr) begin
      trip_nxt = '0;
    end
  end

  // Accumulator, counters and sticky overflow registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc        <= '0;
      trip_dist  <= '0;
      total_dist <= '0;
      overflow   <= 1'b0;
    end else begin
      acc        <= acc_nxt;
      trip_dist  <= trip_nxt;
      total_dist <= total_nxt;
      overflow   <= ovf_nxt;
    end
  end

endmodule
